// File: rtl/fm_hdmi_rx_if.sv
// rtl/fm_hdmi_rx_if.sv - HDMI 16-bit YCbCr 4:2:2 input bus and RGB output bus of fm_hdmi_rx
interface fm_hdmi_rx_if;
  logic        i_hd_vsync;
  logic        i_hd_hsync;
  logic        i_hd_de;
  logic [15:0] i_hd_d;
  logic        o_vsync;
  logic        o_hsync;
  logic        o_de;
  logic [7:0]  o_r;
  logic [7:0]  o_g;
  logic [7:0]  o_b;
  logic        o_chroma_err;

  modport master (
    output i_hd_vsync, i_hd_hsync, i_hd_de, i_hd_d,
    input  o_vsync, o_hsync, o_de, o_r, o_g, o_b, o_chroma_err
  );

  modport slave (
    input  i_hd_vsync, i_hd_hsync, i_hd_de, i_hd_d,
    output o_vsync, o_hsync, o_de, o_r, o_g, o_b, o_chroma_err
  );
endinterface

// File: rtl/fm_hdmi_rx.sv
// rtl/fm_hdmi_rx.sv - YCbCr 4:2:2 HDMI receiver to RGB; optional PP_HDMI_RX_NEG_IN_EN negedge data capture
module fm_hdmi_rx #(
  parameter bit         P_LIMITED_RANGE = 1'b1,
  parameter logic [7:0] P_CHROMA_PAD    = 8'd128
) (
  input logic         clk_v,
  input logic         rst_x,
  fm_hdmi_rx_if.slave hd
);

  localparam logic signed [17:0] K_Y    = P_LIMITED_RANGE ? 18'sd298 : 18'sd256;
  localparam logic signed [17:0] K_YOFF = P_LIMITED_RANGE ? 18'sd16  : 18'sd0;
  localparam logic signed [17:0] K_RCR  = P_LIMITED_RANGE ? 18'sd409 : 18'sd359;
  localparam logic signed [17:0] K_GCR  = P_LIMITED_RANGE ? 18'sd208 : 18'sd183;
  localparam logic signed [17:0] K_GCB  = P_LIMITED_RANGE ? 18'sd100 : 18'sd88;
  localparam logic signed [17:0] K_BCB  = P_LIMITED_RANGE ? 18'sd516 : 18'sd454;

  logic [15:0] in_d;
  logic        in_de;
  logic        in_vs;
  logic        in_hs;

`ifdef PP_HDMI_RX_NEG_IN_EN
  logic [15:0] d_n;
  logic        de_n;
  logic        vs_p;
  logic        hs_p;

  // Data and DE are captured mid-cycle for extra setup margin from the receiver chip
  always_ff @(negedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      d_n  <= 16'd0;
      de_n <= 1'b0;
    end else begin
      d_n  <= hd.i_hd_d;
      de_n <= hd.i_hd_de;
    end
  end

  // Syncs take one extra posedge so they line up with the negedge data path
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      vs_p <= 1'b1;
      hs_p <= 1'b1;
    end else begin
      vs_p <= hd.i_hd_vsync;
      hs_p <= hd.i_hd_hsync;
    end
  end

  assign in_d  = d_n;
  assign in_de = de_n;
  assign in_vs = vs_p;
  assign in_hs = hs_p;
`else
  assign in_d  = hd.i_hd_d;
  assign in_de = hd.i_hd_de;
  assign in_vs = hd.i_hd_vsync;
  assign in_hs = hd.i_hd_hsync;
`endif

  // S1 input registers
  logic [7:0] y1, c1;
  logic       de1, vs1, hs1, hs1_d;
  logic       ph_q, ph1;

  // S2
  logic [7:0] y2, c2;
  logic       de2, ph2, vs2, hs2;

  // S3 rebuilt 4:4:4 pixel
  logic [7:0] y3, cb3, cr3, pair_cb, pair_cr;
  logic       de3, err3, vs3, hs3;

  // S4 products
  logic signed [17:0] y_off, cb_off, cr_off;
  logic signed [17:0] p_yt, p_rcr, p_gcr, p_gcb, p_bcb;
  logic               de4, err4, vs4, hs4;

  // S5 rounded sums, two guard bits above the 18-bit products
  logic [19:0] s_r, s_g, s_b;
  logic        de5, err5, vs5, hs5;

  function automatic logic [19:0] sx(input logic [17:0] v);
    return {{2{v[17]}}, v};
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    logic signed [19:0] sh;
    sh = v >>> 8;
    if (sh[19])
      return 8'd0;
    else if (|sh[18:8])
      return 8'd255;
    else
      return sh[7:0];
  endfunction

  // A new line (DE low) or an hsync rise inside DE forces the pixel to carry Cb
  assign ph1 = (hs1 & ~hs1_d) ? 1'b0 : ph_q;

  // S1 capture, hsync history and chroma phase tracking
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      y1    <= 8'd0;
      c1    <= 8'd0;
      de1   <= 1'b0;
      vs1   <= 1'b1;
      hs1   <= 1'b1;
      hs1_d <= 1'b1;
      ph_q  <= 1'b0;
    end else begin
      y1    <= in_d[15:8];
      c1    <= in_d[7:0];
      de1   <= in_de;
      vs1   <= in_vs;
      hs1   <= in_hs;
      hs1_d <= hs1;
      ph_q  <= de1 ? ~ph1 : 1'b0;
    end
  end

  // S2 delay so the partner pixel of a Cb pixel is visible in S1
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      y2  <= 8'd0;
      c2  <= 8'd0;
      de2 <= 1'b0;
      ph2 <= 1'b0;
      vs2 <= 1'b1;
      hs2 <= 1'b1;
    end else begin
      y2  <= y1;
      c2  <= c1;
      de2 <= de1;
      ph2 <= de1 & ph1;
      vs2 <= vs1;
      hs2 <= hs1;
    end
  end

  // S3 chroma upsampling: Cb pixel borrows Cr from its neighbour, Cr pixel reuses the pair
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      y3      <= 8'd0;
      cb3     <= 8'd0;
      cr3     <= 8'd0;
      pair_cb <= 8'd0;
      pair_cr <= 8'd0;
      de3     <= 1'b0;
      err3    <= 1'b0;
      vs3     <= 1'b1;
      hs3     <= 1'b1;
    end else begin
      de3  <= de2;
      vs3  <= vs2;
      hs3  <= hs2;
      err3 <= 1'b0;
      if (de2 && !ph2 && de1) begin
        y3      <= y2;
        cb3     <= c2;
        cr3     <= c1;
        pair_cb <= c2;
        pair_cr <= c1;
      end else if (de2 && !ph2) begin
        y3   <= y2;
        cb3  <= c2;
        cr3  <= P_CHROMA_PAD;
        err3 <= 1'b1;
      end else if (de2) begin
        y3  <= y2;
        cb3 <= pair_cb;
        cr3 <= pair_cr;
      end else begin
        y3  <= 8'd0;
        cb3 <= 8'd0;
        cr3 <= 8'd0;
      end
    end
  end

  assign y_off  = $signed({10'd0, y3})  - K_YOFF;
  assign cb_off = $signed({10'd0, cb3}) - 18'sd128;
  assign cr_off = $signed({10'd0, cr3}) - 18'sd128;

  // S4 coefficient products
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      p_yt  <= 18'sd0;
      p_rcr <= 18'sd0;
      p_gcr <= 18'sd0;
      p_gcb <= 18'sd0;
      p_bcb <= 18'sd0;
      de4   <= 1'b0;
      err4  <= 1'b0;
      vs4   <= 1'b1;
      hs4   <= 1'b1;
    end else begin
      p_yt  <= K_Y   * y_off;
      p_rcr <= K_RCR * cr_off;
      p_gcr <= K_GCR * cr_off;
      p_gcb <= K_GCB * cb_off;
      p_bcb <= K_BCB * cb_off;
      de4   <= de3;
      err4  <= err3;
      vs4   <= vs3;
      hs4   <= hs3;
    end
  end

  // S5 channel sums with +128 for round-to-nearest on the final shift
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      s_r  <= 20'd0;
      s_g  <= 20'd0;
      s_b  <= 20'd0;
      de5  <= 1'b0;
      err5 <= 1'b0;
      vs5  <= 1'b1;
      hs5  <= 1'b1;
    end else begin
      s_r  <= sx(p_yt) + sx(p_rcr) + 20'd128;
      s_g  <= sx(p_yt) - sx(p_gcr) - sx(p_gcb) + 20'd128;
      s_b  <= sx(p_yt) + sx(p_bcb) + 20'd128;
      de5  <= de4;
      err5 <= err4;
      vs5  <= vs4;
      hs5  <= hs4;
    end
  end

  // S6 scale, clamp and blank into the output registers
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      hd.o_r          <= 8'd0;
      hd.o_g          <= 8'd0;
      hd.o_b          <= 8'd0;
      hd.o_de         <= 1'b0;
      hd.o_chroma_err <= 1'b0;
      hd.o_vsync      <= 1'b1;
      hd.o_hsync      <= 1'b1;
    end else begin
      hd.o_r          <= de5 ? clamp8(s_r) : 8'd0;
      hd.o_g          <= de5 ? clamp8(s_g) : 8'd0;
      hd.o_b          <= de5 ? clamp8(s_b) : 8'd0;
      hd.o_de         <= de5;
      hd.o_chroma_err <= de5 & err5;
      hd.o_vsync      <= vs5;
      hd.o_hsync      <= hs5;
    end
  end

endmodule

// File: tb/tb_fm_hdmi_rx.sv
// tb/tb_fm_hdmi_rx.sv - scoreboard testbench for fm_hdmi_rx
module tb_fm_hdmi_rx;
`ifdef PP_HDMI_RX_NEG_IN_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif
  localparam int PAD = 128;

  logic clk_v = 1'b0;
  logic rst_x = 1'b0;

  fm_hdmi_rx_if bus();

  fm_hdmi_rx #(.P_LIMITED_RANGE(1'b1), .P_CHROMA_PAD(8'd128)) dut (
    .clk_v (clk_v),
    .rst_x (rst_x),
    .hd    (bus)
  );

  always #5 clk_v = ~clk_v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen = 0;
  int de_rise_cyc = -1;
  int vs_fall_cyc = -1;
  logic prev_de = 1'b0;
  logic prev_vs = 1'b1;

  logic [24:0] exp_q[$];
  logic [2:0]  hist_q[$];

  int ln;
  int ly[16];
  int lc[16];
  bit lhs[16];

  function automatic logic [7:0] clip(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  function automatic logic [24:0] model_px(input int y, input int cb, input int cr, input bit err);
    int yt, r, g, b;
    yt = 298 * (y - 16);
    r  = yt + 409 * (cr - 128);
    g  = yt - 208 * (cr - 128) - 100 * (cb - 128);
    b  = yt + 516 * (cb - 128);
    return {clip((r + 128) >>> 8), clip((g + 128) >>> 8), clip((b + 128) >>> 8), err};
  endfunction

  task automatic step(input logic vs, input logic hs, input logic de, input logic [15:0] d);
    logic [2:0]  h;
    logic [24:0] e;
    @(negedge clk_v);
    cyc++;
    h = (hist_q.size() > 0) ? hist_q.pop_front() : 3'b110;
    n_checks++;
    if ({bus.o_vsync, bus.o_hsync, bus.o_de} !== h) begin
      n_fail++;
      $display("FAIL sync_de_align cyc=%0d got vs/hs/de=%b want %b", cyc, {bus.o_vsync, bus.o_hsync, bus.o_de}, h);
    end
    if (bus.o_de === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel cyc=%0d got rgb=%0d,%0d,%0d with empty scoreboard", cyc, bus.o_r, bus.o_g, bus.o_b);
      end else begin
        e = exp_q.pop_front();
        if ({bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err} !== e) begin
          n_fail++;
          $display("FAIL pixel cyc=%0d got rgb=%0d,%0d,%0d err=%b want rgb=%0d,%0d,%0d err=%b", cyc,
                   bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
    end else begin
      n_checks++;
      if ({bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err} !== 25'd0) begin
        n_fail++;
        $display("FAIL blanking cyc=%0d got rgb=%h,%h,%h err=%b want zeros", cyc, bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err);
      end
    end
    if (bus.o_chroma_err === 1'b1) err_seen++;
    if (bus.o_de === 1'b1 && prev_de !== 1'b1) de_rise_cyc = cyc;
    if (bus.o_vsync === 1'b0 && prev_vs === 1'b1) vs_fall_cyc = cyc;
    prev_de = bus.o_de;
    prev_vs = bus.o_vsync;
    #1;
    bus.i_hd_vsync = vs;
    bus.i_hd_hsync = hs;
    bus.i_hd_de    = de;
    bus.i_hd_d     = d;
    hist_q.push_back({vs, hs, de});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  task automatic hpulse();
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    idle(2);
  endtask

  task automatic fill_line(input int n, input int y, input int c);
    ln = n;
    for (int i = 0; i < n; i++) begin
      ly[i] = y; lc[i] = c; lhs[i] = 1'b1;
    end
  endtask

  task automatic model_line();
    bit ph;
    int pcb, pcr, cb, cr;
    bit err;
    ph = 1'b0; pcb = 0; pcr = 0;
    for (int i = 0; i < ln; i++) begin
      if (i == 0 || (lhs[i] && !lhs[i-1])) ph = 1'b0;
      else ph = ~ph;
      if (!ph) begin
        cb = lc[i];
        if (i + 1 < ln) begin cr = lc[i+1]; err = 1'b0; end
        else begin cr = PAD; err = 1'b1; end
        pcb = cb; pcr = cr;
      end else begin
        cb = pcb; cr = pcr; err = 1'b0;
      end
      exp_q.push_back(model_px(ly[i], cb, cr, err));
    end
  endtask

  task automatic drive_line();
    for (int i = 0; i < ln; i++) step(1'b1, lhs[i], 1'b1, {8'(ly[i]), 8'(lc[i])});
  endtask

  task automatic drain(input string name);
    idle(LAT + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_leftover got %0d pixels still expected want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk_v);
    #1;
    hist_q.delete();
    for (int i = 0; i < LAT; i++) hist_q.push_back(3'b110);
    exp_q.delete();
    bus.i_hd_vsync = 1'b1;
    bus.i_hd_hsync = 1'b1;
    bus.i_hd_de    = 1'b0;
    bus.i_hd_d     = 16'h0000;
    prev_de = 1'b0;
    prev_vs = 1'b1;
    rst_x = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_v);
      n_checks++;
      if ({bus.o_vsync, bus.o_hsync, bus.o_de, bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err} !== {3'b110, 25'd0}) begin
        n_fail++;
        $display("FAIL reset_hold got vs/hs/de=%b rgb=%h,%h,%h err=%b want 110 zeros",
                 {bus.o_vsync, bus.o_hsync, bus.o_de}, bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err);
      end
      #1;
      bus.i_hd_de    = 1'b1;
      bus.i_hd_vsync = i[0];
      bus.i_hd_hsync = i[1];
      bus.i_hd_d     = 16'($urandom);
    end
    release_reset();
    idle(LAT + 2);
  endtask

  task automatic test_white_black();
    fill_line(8, 235, 128);
    for (int i = 0; i < 8; i++) exp_q.push_back({8'd255, 8'd255, 8'd255, 1'b0});
    drive_line();
    hpulse();
    fill_line(8, 16, 128);
    for (int i = 0; i < 8; i++) exp_q.push_back({8'd0, 8'd0, 8'd0, 1'b0});
    drive_line();
    drain("white_black");
  endtask

  task automatic test_red();
    ln = 2;
    ly[0] = 81; lc[0] = 90;  lhs[0] = 1'b1;
    ly[1] = 81; lc[1] = 240; lhs[1] = 1'b1;
    exp_q.push_back({8'd255, 8'd0, 8'd0, 1'b0});
    exp_q.push_back({8'd255, 8'd0, 8'd0, 1'b0});
    drive_line();
    drain("red");
  endtask

  task automatic test_latency();
    int t_de, t_vs;
    de_rise_cyc = -1;
    vs_fall_cyc = -1;
    idle(3);
    t_vs = cyc + 1;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    idle(3);
    fill_line(4, 120, 90);
    model_line();
    t_de = cyc + 1;
    drive_line();
    drain("latency");
    n_checks++;
    if (de_rise_cyc - t_de !== LAT) begin
      n_fail++;
      $display("FAIL de_latency got %0d cycles want %0d", de_rise_cyc - t_de, LAT);
    end
    n_checks++;
    if (vs_fall_cyc - t_vs !== LAT) begin
      n_fail++;
      $display("FAIL vsync_latency got %0d cycles want %0d", vs_fall_cyc - t_vs, LAT);
    end
  endtask

  task automatic test_odd_line();
    int e0;
    e0 = err_seen;
    ln = 3;
    ly[0] = 100; lc[0] = 200; lhs[0] = 1'b1;
    ly[1] = 100; lc[1] = 60;  lhs[1] = 1'b1;
    ly[2] = 100; lc[2] = 50;  lhs[2] = 1'b1;
    model_line();
    drive_line();
    drain("odd_line");
    n_checks++;
    if (err_seen - e0 !== 1) begin
      n_fail++;
      $display("FAIL chroma_err_count got %0d pulses want 1", err_seen - e0);
    end
  endtask

  task automatic test_hsync_mid();
    ln = 4;
    ly[0] = 60;  lc[0] = 70;  lhs[0] = 1'b0;
    ly[1] = 150; lc[1] = 180; lhs[1] = 1'b1;
    ly[2] = 90;  lc[2] = 40;  lhs[2] = 1'b1;
    ly[3] = 200; lc[3] = 110; lhs[3] = 1'b1;
    model_line();
    drive_line();
    hpulse();
    fill_line(6, 140, 0);
    for (int i = 0; i < 6; i++) lc[i] = 64 + 20 * i;
    model_line();
    drive_line();
    drain("hsync_mid");
  endtask

  task automatic test_reset_midline();
    fill_line(3, 180, 30);
    drive_line();
    @(negedge clk_v);
    #1;
    rst_x = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_vsync, bus.o_hsync, bus.o_de, bus.o_r, bus.o_g, bus.o_b, bus.o_chroma_err} !== {3'b110, 25'd0}) begin
      n_fail++;
      $display("FAIL reset_async got vs/hs/de=%b rgb=%h,%h,%h want 110 zeros",
               {bus.o_vsync, bus.o_hsync, bus.o_de}, bus.o_r, bus.o_g, bus.o_b);
    end
    release_reset();
    idle(2);
    ln = 4;
    for (int i = 0; i < 4; i++) begin
      ly[i] = 50 + 40 * i; lc[i] = 220 - 45 * i; lhs[i] = 1'b1;
    end
    model_line();
    drive_line();
    drain("reset_midline");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      ln = 4 + k;
      for (int i = 0; i < ln; i++) begin
        ly[i] = 16 + int'($urandom_range(0, 219));
        lc[i] = 16 + int'($urandom_range(0, 224));
        lhs[i] = 1'b1;
      end
      model_line();
      drive_line();
      idle(1);
    end
    drain("back_to_back");
  endtask

  initial begin
    bus.i_hd_vsync = 1'b1;
    bus.i_hd_hsync = 1'b1;
    bus.i_hd_de    = 1'b0;
    bus.i_hd_d     = 16'h0000;
    test_reset();
    test_white_black();
    test_red();
    test_latency();
    test_odd_line();
    test_hsync_mid();
    test_reset_midline();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
